// File: rtl/polyphonic_tone_pwm.sv
// rtl/polyphonic_tone_pwm.sv - multi-channel square-wave tone generator with ASR envelopes and PWM mixer
`timescale 1ns/1ps
module polyphonic_tone_pwm #(
  parameter int CHANNELS        = 3,
  parameter int HALF_PERIOD_W   = 16,
  parameter int VOLUME_W        = 4,
  parameter int ENV_STEP_CYCLES = 12000
) (
  input  logic                              clock_12_mhz,
  input  logic                              reset_n,
  input  logic [CHANNELS-1:0]               gate,
  input  logic [CHANNELS*HALF_PERIOD_W-1:0] half_period,
  input  logic [CHANNELS*VOLUME_W-1:0]      volume,
  output logic [CHANNELS-1:0]               square,
  output logic [CHANNELS-1:0]               active,
  output logic                              pwm_out
);
  localparam int SUM_W = VOLUME_W + 3;
  localparam int PRE_W = (ENV_STEP_CYCLES > 1) ? $clog2(ENV_STEP_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(ENV_STEP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ATTACK, S_SUSTAIN, S_RELEASE} env_state_t;

  env_state_t                              r_state [CHANNELS];
  logic [CHANNELS-1:0][VOLUME_W-1:0]       r_env;
  logic [CHANNELS-1:0][HALF_PERIOD_W-1:0]  r_half;
  logic [CHANNELS-1:0][HALF_PERIOD_W-1:0]  r_count;
  logic [CHANNELS-1:0]                     r_square;
  logic [PRE_W-1:0]                        r_prescale;
  logic [SUM_W-1:0]                        r_pwm_count;
  logic [SUM_W-1:0]                        r_latched_sum;
  logic                                    r_pwm_out;

  logic [CHANNELS-1:0][HALF_PERIOD_W-1:0]  w_half_in;
  logic [CHANNELS-1:0][HALF_PERIOD_W-1:0]  w_half_eff;
  logic [CHANNELS-1:0][VOLUME_W-1:0]       w_vol;
  logic [CHANNELS-1:0]                     w_release_done;
  logic                                    w_env_tick;
  logic [SUM_W-1:0]                        w_sum;
  logic [SUM_W-1:0]                        w_frame_sum;

  assign w_half_in  = half_period;
  assign w_vol      = volume;
  assign w_env_tick = (r_prescale == PRE_LAST);

  // A silent channel (latched H = 0) follows the live pitch so a new H starts immediately.
  always_comb begin
    w_half_eff     = '0;
    w_release_done = '0;
    active         = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_half_eff[i]     = (r_half[i] == '0) ? w_half_in[i] : r_half[i];
      w_release_done[i] = (r_state[i] == S_RELEASE) && !gate[i] && w_env_tick && (r_env[i] == '0);
      active[i]         = (r_state[i] != S_IDLE);
    end
  end

  always_ff @(posedge clock_12_mhz or negedge reset_n) begin
    if (!reset_n)        r_prescale <= '0;
    else if (w_env_tick) r_prescale <= '0;
    else                 r_prescale <= r_prescale + 1'b1;
  end

  // Gate edges take priority over envelope ticks in every state.
  always_ff @(posedge clock_12_mhz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) r_state[i] <= S_IDLE;
      r_env <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        case (r_state[i])
          S_IDLE: begin
            r_env[i] <= '0;
            if (gate[i]) r_state[i] <= S_ATTACK;
          end
          S_ATTACK: begin
            if (!gate[i]) r_state[i] <= S_RELEASE;
            else if (w_env_tick) begin
              if (r_env[i] >= w_vol[i]) begin
                r_env[i]   <= w_vol[i];
                r_state[i] <= S_SUSTAIN;
              end else begin
                r_env[i] <= r_env[i] + 1'b1;
              end
            end
          end
          S_SUSTAIN: begin
            if (!gate[i]) r_state[i] <= S_RELEASE;
            else          r_env[i]   <= w_vol[i];
          end
          S_RELEASE: begin
            if (gate[i]) r_state[i] <= S_ATTACK;
            else if (w_env_tick) begin
              if (r_env[i] == '0) r_state[i] <= S_IDLE;
              else                r_env[i]   <= r_env[i] - 1'b1;
            end
          end
          default: r_state[i] <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock_12_mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_half   <= '0;
      r_count  <= '0;
      r_square <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if ((r_state[i] == S_IDLE) || w_release_done[i]) begin
          r_count[i]  <= '0;
          r_square[i] <= 1'b0;
          r_half[i]   <= gate[i] ? w_half_in[i] : '0;
        end else if (w_half_eff[i] == '0) begin
          r_count[i]  <= '0;
          r_square[i] <= 1'b0;
        end else if (r_count[i] == (w_half_eff[i] - 1'b1)) begin
          r_count[i]  <= '0;
          r_square[i] <= ~r_square[i];
          r_half[i]   <= w_half_in[i];
        end else begin
          r_count[i] <= r_count[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (r_square[i]) w_sum = w_sum + SUM_W'(r_env[i]);
    end
  end

  // The mix level only changes at frame start so each PWM frame has one clean duty.
  assign w_frame_sum = (r_pwm_count == '0) ? w_sum : r_latched_sum;

  always_ff @(posedge clock_12_mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_count   <= '0;
      r_latched_sum <= '0;
      r_pwm_out     <= 1'b0;
    end else begin
      r_pwm_count   <= r_pwm_count + 1'b1;
      r_latched_sum <= w_frame_sum;
      r_pwm_out     <= (r_pwm_count < w_frame_sum);
    end
  end

  assign square  = r_square;
  assign pwm_out = r_pwm_out;
endmodule
